serial_addsub_ctrl: RTL and testbench
=====================================

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand/result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, the request to begin an operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2, the operation select: 00 ADD A+B; 01 SUB A-B; 10 NEG 0-A (two's complement of A); 11 PASS A+0.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, the operands, sampled only on the start-accept edge.
REQ-007 The block SHALL have port busy, output, 1, high in LOAD and RUN.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, WIDTH, the sum/difference, held stable from done until the next accepted start.
REQ-010 The block SHALL have ports carry and ovf, output, 1 each, the unsigned carry-out and the signed overflow flag, held with result.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, RUN and DONE, which SHALL be the only reachable states.
REQ-012 IDLE SHALL go to LOAD on the first edge with start=1, latching op, a and b on that edge.
REQ-013 LOAD SHALL take one cycle and set up the datapath: operand X = a (00, 01, 11) or ~a (10); operand Y = b (00), ~b (01) or all-zero (10, 11); carry reg = 1 for 01 and 10, else 0; bit counter = 0.
REQ-014 RUN SHALL process one bit per cycle, LSB first, through a single shared full_adder instance with fA=X[cnt], fB=Y[cnt] and cIn=carry reg, writing fY into result[cnt], updating the carry reg from cOut, and incrementing cnt.
REQ-015 RUN SHALL last exactly WIDTH cycles, and on the edge where cnt=WIDTH-1 SHALL capture carry = cOut and ovf = cIn XOR cOut of the MSB step, then go to DONE.
REQ-016 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be: start sampled at edge k, done high during the cycle after edge k+WIDTH+1 (6 edges for WIDTH=4), with throughput of one operation per WIDTH+3 cycles.
REQ-018 start SHALL be ignored while busy=1 or done=1, with no queueing.
REQ-019 start held high continuously SHALL begin a new operation on the first IDLE edge after done.
REQ-020 op, a and b changing after the accept edge SHALL NOT affect the operation in flight.
REQ-021 result SHALL wrap modulo 2^WIDTH; carry for SUB SHALL be 1 when a>=b unsigned (no borrow); NEG of the most negative value SHALL return that same value with ovf=1.
REQ-022 result, carry and ovf SHALL update bitwise during RUN, and SHALL be valid only from the done cycle onward.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, result=0, carry=0, ovf=0, cnt=0 and carry reg=0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse, and the first start after rst_n rises SHALL behave as from power-up.
REQ-025 Reset deassertion SHALL be synchronous to clk, and start SHALL NOT be accepted on the same edge that rst_n rises.

Structure
REQ-026 Package serial_addsub_pkg SHALL hold the state enumeration and the op code constants OP_ADD, OP_SUB, OP_NEG and OP_PASS.
REQ-027 The block SHALL instantiate exactly one existing full_adder (fA, fB, cIn -> fY, cOut) as its only sub-module, and SHALL NOT infer any other adder.
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide, and all registers SHALL be in one clocked process with async reset.

Verification
REQ-029 The bench SHALL cover ADD a=0101 b=0011 -> result=1000, carry=0, ovf=1, with done exactly 6 edges after the start edge.
REQ-030 The bench SHALL cover SUB a=0011 b=0101 -> result=1110, carry=0, ovf=0; and SUB a=0101 b=0011 -> result=0010, carry=1.
REQ-031 The bench SHALL cover NEG a=0101 -> result=1011, ovf=0; NEG a=1000 -> result=1000, ovf=1; NEG a=0000 -> result=0000, carry=1.
REQ-032 The bench SHALL cover ADD 1111+0001 -> result=0000, carry=1, ovf=0, with a second start pulsed during RUN ignored (one done pulse only).
REQ-033 The bench SHALL cover rst_n pulsed low during RUN cnt=2 -> outputs 0 and state IDLE, no done; next ADD 0010+0010 -> 0100 with normal latency.
REQ-034 The bench SHALL cover start held high for 20 cycles -> back-to-back operations with done every 7 cycles, and operand changes mid-RUN not reflected in result.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and op codes for the bit-serial add/subtract controller.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEG  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module full_adder (
    input  logic fA,
    input  logic fB,
    input  logic cIn,
    output logic fY,
    output logic cOut
);

    // Sum and carry of a single bit position.
    assign fY   = fA ^ fB ^ cIn;
    assign cOut = (fA & fB) | (cIn & (fA ^ fB));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial ADD/SUB/NEG/PASS unit: one result bit per clock, LSB first,
// through a single shared full adder.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_ovf;

    logic               w_fa;
    logic               w_fb;
    logic               w_fy;
    logic               w_cout;

    // Current bit slice presented to the shared adder.
    assign w_fa = r_x[r_cnt];
    assign w_fb = r_y[r_cnt];

    full_adder u_fa (
        .fA   (w_fa),
        .fB   (w_fb),
        .cIn  (r_c),
        .fY   (w_fy),
        .cOut (w_cout)
    );

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = RUN;
            RUN:     if (r_cnt == CNT_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, operand capture, serial datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == LOAD) || (w_next == RUN);
            r_done  <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                LOAD: begin
                    r_cnt <= '0;
                    // Subtraction and negation are done as X + ~Y + 1.
                    case (r_op)
                        OP_ADD: begin
                            r_x <= r_a;
                            r_y <= r_b;
                            r_c <= 1'b0;
                        end
                        OP_SUB: begin
                            r_x <= r_a;
                            r_y <= ~r_b;
                            r_c <= 1'b1;
                        end
                        OP_NEG: begin
                            r_x <= ~r_a;
                            r_y <= '0;
                            r_c <= 1'b1;
                        end
                        default: begin
                            r_x <= r_a;
                            r_y <= '0;
                            r_c <= 1'b0;
                        end
                    endcase
                end
                RUN: begin
                    r_result[r_cnt] <= w_fy;
                    r_c             <= w_cout;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_carry <= w_cout;
                        r_ovf   <= r_c ^ w_cout;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl with an arithmetic reference model.
module tb_serial_addsub_ctrl;
    import serial_addsub_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .ovf    (ovf)
    );

    // Directed vectors: op, a, b -> result, carry, ovf.
    localparam logic [1:0]   D_OP [7] = '{OP_ADD, OP_SUB, OP_SUB, OP_NEG, OP_NEG, OP_NEG, OP_PASS};
    localparam logic [W-1:0] D_A  [7] = '{4'b0101, 4'b0011, 4'b0101, 4'b0101, 4'b1000, 4'b0000, 4'b1001};
    localparam logic [W-1:0] D_B  [7] = '{4'b0011, 4'b0101, 4'b0011, 4'b0110, 4'b0001, 4'b1111, 4'b0111};
    localparam logic [W-1:0] D_R  [7] = '{4'b1000, 4'b1110, 4'b0010, 4'b1011, 4'b1000, 4'b0000, 4'b1001};
    localparam logic         D_C  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic         D_V  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reference: plain integer arithmetic, signed overflow from the true signed result.
    function automatic void model(input logic [1:0] o, input int ua, input int ub,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int sa, sb, t, ur;
        sa = (ua >= M/2) ? ua - M : ua;
        sb = (ub >= M/2) ? ub - M : ub;
        case (o)
            OP_ADD:  begin ur = (ua + ub) % M;     c = ((ua + ub) >= M); t = sa + sb; end
            OP_SUB:  begin ur = (ua - ub + M) % M; c = (ua >= ub);       t = sa - sb; end
            OP_NEG:  begin ur = (M - ua) % M;      c = (ua == 0);        t = -sa;     end
            default: begin ur = ua;                c = 1'b0;             t = sa;      end
        endcase
        r = W'(ur);
        v = (t < -(M/2)) || (t >= M/2);
    endfunction

    // Wait (bounded) at falling edges until the unit is idle.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%b done=%b still set after %0d cycles", busy, done, n);
        end
    endtask

    // Issue one operation; lat counts clock edges with the accept edge as 1.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [W-1:0] r, output logic c, output logic v, output int lat);
        wait_idle();
        op = o; a = xa; b = xb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n + 1;
                break;
            end
        end
        r = result; c = carry; v = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = OP_ADD; a = '0; b = '0;
        @(negedge clk);
        checks++;
        if ({busy, done, carry, ovf, result} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {busy, done, carry, ovf, result});
        end
        start = 1'b1; a = 4'b0111; b = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: busy,done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] r;
        logic c, v;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(D_OP[i], D_A[i], D_B[i], r, c, v, lat);
            checks++;
            if ({r, c, v} !== {D_R[i], D_C[i], D_V[i]}) begin
                errors++;
                $display("FAIL directed_%0d: result,carry,ovf=%b,%b,%b expected %b,%b,%b",
                         i, r, c, v, D_R[i], D_C[i], D_V[i]);
            end
            checks++;
            if (lat != W + 2) begin
                errors++;
                $display("FAIL directed_latency_%0d: got %0d edges expected %0d", i, lat, W + 2);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL directed_done_width_%0d: done=%b expected 0", i, done);
            end
        end
    endtask

    task automatic test_second_start();
        int dones, first;
        logic [W-1:0] r;
        logic c, v;
        dones = 0; first = -1; r = '0; c = 1'b0; v = 1'b0;
        wait_idle();
        op = OP_ADD; a = 4'b1111; b = 4'b0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                if (first < 0) begin
                    first = n + 1;
                    r = result; c = carry; v = ovf;
                end
            end
            if (n == 2) begin
                start = 1'b1; op = OP_SUB; a = 4'b0001; b = 4'b0100;
            end
            if (n == 3) start = 1'b0;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL second_start_done_count: got %0d expected 1", dones);
        end
        checks++;
        if ({r, c, v} !== {4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL second_start_result: result,carry,ovf=%b,%b,%b expected 0000,1,0", r, c, v);
        end
        checks++;
        if (first != W + 2) begin
            errors++;
            $display("FAIL second_start_latency: got %0d expected %0d", first, W + 2);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r;
        logic c, v;
        int lat, dones;
        dones = 0;
        wait_idle();
        op = OP_ADD; a = 4'b0111; b = 4'b0110; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, carry, ovf, result} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b expected 0", {busy, done, carry, ovf, result});
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
        end
        do_op(OP_ADD, 4'b0010, 4'b0010, r, c, v, lat);
        checks++;
        if ({r, c, v} !== {4'b0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_next_op: result,carry,ovf=%b,%b,%b expected 0100,0,0", r, c, v);
        end
        checks++;
        if (lat != W + 2) begin
            errors++;
            $display("FAIL reset_mid_latency: got %0d expected %0d", lat, W + 2);
        end
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [W-1:0] xa, xb, r, er;
        logic c, v, ec, ev;
        int lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom); xa = W'($urandom); xb = W'($urandom);
            do_op(o, xa, xb, r, c, v, lat);
            model(o, int'(xa), int'(xb), er, ec, ev);
            checks++;
            if ({r, c, v} !== {er, ec, ev} || lat != W + 2) begin
                errors++;
                $display("FAIL random_%0d op=%b a=%b b=%b: result,carry,ovf=%b,%b,%b lat=%0d expected %b,%b,%b lat=%0d",
                         i, o, xa, xb, r, c, v, lat, er, ec, ev, W + 2);
            end
        end
    endtask

    // start held high: accepts every W+3 edges, operands seen only at accept edges.
    task automatic test_back_to_back();
        logic [1:0]   hop [30];
        logic [W-1:0] ha  [30];
        logic [W-1:0] hb  [30];
        logic [W-1:0] er;
        logic ec, ev, exp_done;
        int period, k;
        period = W + 3;
        wait_idle();
        for (int n = 0; n < 30; n++) begin
            hop[n] = 2'($urandom); ha[n] = W'($urandom); hb[n] = W'($urandom);
            if (n < 20) begin
                start = 1'b1; op = hop[n]; a = ha[n]; b = hb[n];
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            k = n - (W + 1);
            exp_done = (k >= 0) && (k < 20) && ((k % period) == 0);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL b2b_done_edge_%0d: done=%b expected %b", n, done, exp_done);
            end
            if (exp_done && done) begin
                model(hop[k], int'(ha[k]), int'(hb[k]), er, ec, ev);
                checks++;
                if ({result, carry, ovf} !== {er, ec, ev}) begin
                    errors++;
                    $display("FAIL b2b_result_edge_%0d: result,carry,ovf=%b,%b,%b expected %b,%b,%b",
                             n, result, carry, ovf, er, ec, ev);
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_second_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
